reg_bank_hs: RTL and testbench

REG_BANK_HS -- requirements
Module: reg_bank_hs

---
 rtl/reg_bank_hs.sv | 124 ++++++++++++
 tb/tb_reg_bank_hs.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_hs.sv
// Register bank with a valid/ready request/response handshake: control registers,
// sticky W1C status registers, an interrupt enable mask and a registered interrupt.
module reg_bank_hs #(
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int N_CTRL = 4,
   parameter int N_STAT = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AW-1:0]        req_addr_i,
   input  logic [DW-1:0]        req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DW-1:0]        rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic [N_CTRL*DW-1:0] ctrl_o,
   input  logic [N_STAT*DW-1:0] status_in_i,
   output logic                 irq_o
);

   localparam int WW = AW - 2;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   logic [0:0]        state_q;
   logic [DW-1:0]     ctrl_q [N_CTRL];
   logic [DW-1:0]     stat_q [N_STAT];
   logic [DW-1:0]     irq_en_q;
   logic [DW-1:0]     irq_pend;
   logic [DW-1:0]     rd_mux;
   logic [DW-1:0]     rdata_q;
   logic              err_q;
   logic              irq_q;
   logic [WW-1:0]     word;
   logic              aligned;
   logic [N_CTRL-1:0] ctrl_sel;
   logic [N_STAT-1:0] stat_sel;
   logic              en_sel;
   logic              pend_sel;
   logic              err;
   logic              accept;
   logic              wr;

   // Full-width word compare per register, so no upper address bits are ignored.
   assign word    = req_addr_i[AW-1:2];
   assign aligned = (req_addr_i[1:0] == 2'b00);

   // NOTE: every combinational output gets a default before the loops so no latch is inferred.
   always_comb begin
      ctrl_sel = '0;
      stat_sel = '0;
      for (int i = 0; i < N_CTRL; i++) ctrl_sel[i] = aligned && (word == WW'(i));
      for (int j = 0; j < N_STAT; j++) stat_sel[j] = aligned && (word == WW'(16 + j));
      en_sel   = aligned && (word == WW'(32));
      pend_sel = aligned && (word == WW'(33));
      err      = !((|ctrl_sel) || (|stat_sel) || en_sel || (pend_sel && !req_we_i));
   end

   always_comb begin
      irq_pend = '0;
      for (int j = 0; j < N_STAT; j++) irq_pend[j] = |(stat_q[j] & irq_en_q);
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_CTRL; i++) if (ctrl_sel[i]) rd_mux = ctrl_q[i];
      for (int j = 0; j < N_STAT; j++) if (stat_sel[j]) rd_mux = stat_q[j];
      if (en_sel)   rd_mux = irq_en_q;
      if (pend_sel) rd_mux = irq_pend;
   end

   assign accept = req_valid_i && (state_q == S_IDLE);
   assign wr     = accept && req_we_i && !err;

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         irq_q <= |irq_pend;
         if (accept) begin
            state_q <= S_RESP;
            rdata_q <= (req_we_i || err) ? '0 : rd_mux;
            err_q   <= err;
         end else if ((state_q == S_RESP) && rsp_ready_i) begin
            state_q <= S_IDLE;
         end
      end
   end

   // NOTE: the register arrays are flops, not a RAM macro, so they take the async reset too.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_CTRL; i++) ctrl_q[i] <= '0;
         for (int j = 0; j < N_STAT; j++) stat_q[j] <= '0;
         irq_en_q <= '0;
      end else begin
         for (int i = 0; i < N_CTRL; i++) if (wr && ctrl_sel[i]) ctrl_q[i] <= req_wdata_i;
         // Set pulses are OR-ed in after the clear, so a same-cycle set wins.
         for (int j = 0; j < N_STAT; j++)
            stat_q[j] <= (stat_q[j] & ~((wr && stat_sel[j]) ? req_wdata_i : '0))
                         | status_in_i[j*DW +: DW];
         if (wr && en_sel) irq_en_q <= req_wdata_i;
      end
   end

   for (genvar i = 0; i < N_CTRL; i++) begin : g_ctrl_out
      assign ctrl_o[i*DW +: DW] = ctrl_q[i];
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_reg_bank_hs.sv
// Bench for reg_bank_hs: directed vector table, hand-written handshake/irq/reset
// sequences and random traffic, all checked every cycle against an address-map model.
module tb_reg_bank_hs;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NC = 4;
   localparam int NS = 2;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             req_valid_i = 1'b0;
   logic             req_ready_o;
   logic             req_we_i = 1'b0;
   logic [AW-1:0]    req_addr_i = '0;
   logic [DW-1:0]    req_wdata_i = '0;
   logic             rsp_valid_o;
   logic             rsp_ready_i = 1'b0;
   logic [DW-1:0]    rsp_rdata_o;
   logic             rsp_err_o;
   logic [NC*DW-1:0] ctrl_o;
   logic [NS*DW-1:0] status_in_i = '0;
   logic             irq_o;

   reg_bank_hs #(.AW(AW), .DW(DW), .N_CTRL(NC), .N_STAT(NS)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .ctrl_o      (ctrl_o),
      .status_in_i (status_in_i),
      .irq_o       (irq_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: registers by address, a busy flag for an outstanding response.
   logic [DW-1:0] m_ctrl [NC];
   logic [DW-1:0] m_stat [NS];
   logic [DW-1:0] m_en;
   logic [DW-1:0] m_rdata;
   bit            m_busy;
   bit            m_err;
   bit            m_irq;

   function automatic logic [DW-1:0] m_pend();
      logic [DW-1:0] p = '0;
      for (int j = 0; j < NS; j++) p[j] = |(m_stat[j] & m_en);
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) m_ctrl[i] = '0;
      for (int j = 0; j < NS; j++) m_stat[j] = '0;
      m_en = '0; m_rdata = '0; m_busy = 0; m_err = 0; m_irq = 0;
   endtask

   task automatic model_step(input bit v, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input bit rr, input logic [NS*DW-1:0] st);
      int            ai;
      bit            next_irq;
      bit            e;
      logic [DW-1:0] rd;
      logic [DW-1:0] clr [NS];
      ai = int'(a);
      next_irq = |m_pend();
      for (int j = 0; j < NS; j++) clr[j] = '0;
      if (!m_busy && v) begin
         e  = 1;
         rd = '0;
         if (ai % 4 == 0) begin
            if (ai < 4 * NC) begin
               e = 0; rd = m_ctrl[ai/4];
               if (we) m_ctrl[ai/4] = wd;
            end else if (ai >= 64 && ai < 64 + 4 * NS) begin
               e = 0; rd = m_stat[(ai-64)/4];
               if (we) clr[(ai-64)/4] = wd;
            end else if (ai == 128) begin
               e = 0; rd = m_en;
               if (we) m_en = wd;
            end else if (ai == 132 && !we) begin
               e = 0; rd = m_pend();
            end
         end
         m_busy  = 1;
         m_err   = e;
         m_rdata = (we || e) ? '0 : rd;
      end else if (m_busy && rr) begin
         m_busy = 0;
      end
      for (int j = 0; j < NS; j++) m_stat[j] = (m_stat[j] & ~clr[j]) | st[j*DW +: DW];
      m_irq = next_irq;
   endtask

   task automatic check_outputs();
      logic [NC*DW-1:0] exp_ctrl;
      for (int i = 0; i < NC; i++) exp_ctrl[i*DW +: DW] = m_ctrl[i];
      check("req_ready", req_ready_o, !m_busy);
      check("rsp_valid", rsp_valid_o, m_busy);
      if (m_busy) begin
         check("rsp_rdata", rsp_rdata_o, m_rdata);
         check("rsp_err", rsp_err_o, m_err);
      end
      check("ctrl_o", ctrl_o, exp_ctrl);
      check("irq_o", irq_o, m_irq);
   endtask

   // Called at a falling edge: drive, advance one rising edge, compare at the next falling edge.
   task automatic cycle(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit rr, input logic [NS*DW-1:0] st);
      req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = wd;
      rsp_ready_i = rr; status_in_i = st;
      model_step(v, we, a, wd, rr, st);
      @(posedge clk_i);
      @(negedge clk_i);
      check_outputs();
   endtask

   task automatic txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      output logic [DW-1:0] rd, output logic e);
      cycle(1, we, a, wd, 0, '0);
      rd = rsp_rdata_o;
      e  = rsp_err_o;
      cycle(0, 0, '0, '0, 1, '0);
   endtask

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] rd;
      logic          e;
      logic [7:0]    pool [12];

      vecs[0]  = '{1'b1, 8'h04, 32'hA5A5_0001, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 8'h04, 32'h0, 32'hA5A5_0001, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 32'h0, 32'h0, 1'b0};
      vecs[3]  = '{1'b1, 8'h02, 32'hDEAD_BEEF, 32'h0, 1'b1};
      vecs[4]  = '{1'b0, 8'h10, 32'h0, 32'h0, 1'b1};
      vecs[5]  = '{1'b0, 8'h48, 32'h0, 32'h0, 1'b1};
      vecs[6]  = '{1'b1, 8'h84, 32'hFFFF_FFFF, 32'h0, 1'b1};
      vecs[7]  = '{1'b1, 8'h10, 32'h0000_FFFF, 32'h0, 1'b1};
      vecs[8]  = '{1'b0, 8'hC4, 32'h0, 32'h0, 1'b1};
      vecs[9]  = '{1'b0, 8'h44, 32'h0, 32'h0, 1'b0};
      vecs[10] = '{1'b1, 8'h80, 32'h0000_0008, 32'h0, 1'b0};
      vecs[11] = '{1'b0, 8'h80, 32'h0, 32'h0000_0008, 1'b0};
      vecs[12] = '{1'b0, 8'h84, 32'h0, 32'h0, 1'b0};
      vecs[13] = '{1'b0, 8'h04, 32'h0, 32'hA5A5_0001, 1'b0};
      vecs[14] = '{1'b1, 8'h88, 32'h1, 32'h0, 1'b1};
      vecs[15] = '{1'b0, 8'h08, 32'h0, 32'h0, 1'b0};

      // Reset state
      model_reset();
      repeat (2) @(negedge clk_i);
      check("rst rsp_valid", rsp_valid_o, 1'b0);
      check("rst rsp_rdata", rsp_rdata_o, '0);
      check("rst rsp_err", rsp_err_o, 1'b0);
      check("rst irq", irq_o, 1'b0);
      check("rst ctrl", ctrl_o, '0);
      rst_ni = 1'b1;
      check("rst ready", req_ready_o, 1'b1);

      // Directed vectors
      for (int i = 0; i < NV; i++) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e);
         check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d err", i), e, vecs[i].exp_err);
      end
      check("ctrl1 slice", ctrl_o[63:32], 32'hA5A5_0001);

      // Sticky status, then set-wins against a same-cycle W1C
      cycle(0, 0, '0, '0, 0, 64'h8);
      txn(0, 8'h40, '0, rd, e);
      check("stat read", rd, 32'h8);
      cycle(1, 1, 8'h40, 32'h8, 0, 64'h8);
      cycle(0, 0, '0, '0, 1, '0);
      txn(0, 8'h40, '0, rd, e);
      check("stat set wins", rd, 32'h8);

      // Interrupt: IRQ_EN=8 from the table; clear, re-pulse, observe two-edge latency
      check("irq from stat", irq_o, 1'b1);
      txn(1, 8'h40, 32'h8, rd, e);
      check("irq cleared", irq_o, 1'b0);
      cycle(0, 0, '0, '0, 0, 64'h8);
      check("irq one edge", irq_o, 1'b0);
      cycle(0, 0, '0, '0, 0, '0);
      check("irq two edges", irq_o, 1'b1);
      txn(0, 8'h84, '0, rd, e);
      check("irq_pend read", rd, 32'h1);
      cycle(1, 1, 8'h40, 32'h8, 0, '0);
      check("irq at clear edge", irq_o, 1'b1);
      cycle(0, 0, '0, '0, 1, '0);
      check("irq after clear", irq_o, 1'b0);

      // Backpressure: response held while a new write waits
      txn(1, 8'h00, 32'h1234_5678, rd, e);
      cycle(1, 0, 8'h00, '0, 0, '0);
      for (int k = 0; k < 5; k++) begin
         cycle(1, 1, 8'h08, 32'hCAFE_F00D, 0, '0);
         check("hold rdata", rsp_rdata_o, 32'h1234_5678);
         check("hold ready", req_ready_o, 1'b0);
      end
      cycle(1, 1, 8'h08, 32'hCAFE_F00D, 1, '0);
      check("no same-cycle accept", ctrl_o[95:64], 32'h0);
      check("idle after ready", rsp_valid_o, 1'b0);
      cycle(1, 1, 8'h08, 32'hCAFE_F00D, 0, '0);
      check("write after ready", ctrl_o[95:64], 32'hCAFE_F00D);
      cycle(0, 0, '0, '0, 1, '0);

      // Reset in RESP with irq high
      cycle(0, 0, '0, '0, 0, 64'h8);
      cycle(0, 0, '0, '0, 0, '0);
      check("irq before reset", irq_o, 1'b1);
      cycle(1, 0, 8'h04, '0, 0, '0);
      check("resp before reset", rsp_valid_o, 1'b1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async rsp_valid", rsp_valid_o, 1'b0);
      check("async irq", irq_o, 1'b0);
      check("async ctrl", ctrl_o, '0);
      check("async rdata", rsp_rdata_o, '0);
      model_reset();
      req_valid_i = 0; rsp_ready_i = 0; status_in_i = '0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      check("post-reset ready", req_ready_o, 1'b1);
      repeat (3) cycle(0, 0, '0, '0, 0, '0);
      check("no stale rsp", rsp_valid_o, 1'b0);

      // Random traffic
      pool = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40, 8'h44, 8'h48, 8'h80, 8'h84, 8'h02, 8'hC0};
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0]    a;
         logic [NS*DW-1:0] st;
         a  = ($urandom % 8 == 0) ? AW'($urandom) : pool[$urandom % 12];
         st = ($urandom % 4 == 0) ? {32'($urandom) & 32'($urandom), 32'($urandom) & 32'($urandom)} : '0;
         cycle(1'($urandom), 1'($urandom), a, 32'($urandom), ($urandom % 3) != 0, st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
